// File: rtl/pot_paddle_emulator.sv
// Paddle/pot responder for POKEY: turns the dump line into timed threshold crossings per pot.
// Latency: a pot line rises one clk after the scan count reaches its latched value; dump is sampled one clk late.
// No backpressure: the block free-runs against dump. Optional jitter dither is enabled by POT_JITTER_EN.
module pot_paddle_emulator #(
  parameter int NUM_POTS  = 2,
  parameter int TICK_DIV  = 114,
  parameter int MAX_COUNT = 228
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dump,
  input  logic                  fast_scan,
  input  logic [8*NUM_POTS-1:0] pot_value,
  output logic [NUM_POTS-1:0]   pot_line,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(MAX_COUNT + 1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] ST_DUMP   = 2'd0;
  localparam logic [1:0] ST_CHARGE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_COUNT);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic                dump_q;
  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [NUM_POTS-1:0] pot_line_q, pot_line_d;
  logic [CW-1:0]       shadow_q [NUM_POTS];
  logic [CW-1:0]       shadow_d [NUM_POTS];
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tick;
`ifdef POT_JITTER_EN
  logic [7:0]          lfsr_q, lfsr_d;
`endif

  // Saturate a (possibly dithered) 9-bit position to the top of the scan range.
  function automatic logic [CW-1:0] clamp_pos(input logic [8:0] v);
    if (v > 9'(MAX_COUNT)) return CNT_MAX;
    return CW'(v);
  endfunction

  // Next-state logic for the dump/charge/done scan sequence.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    presc_d    = presc_q;
    pot_line_d = pot_line_q;
    shadow_d   = shadow_q;
    tick       = 1'b0;
`ifdef POT_JITTER_EN
    lfsr_d     = lfsr_q;
`endif
    case (state_q)
      ST_DUMP: begin
        count_d    = '0;
        presc_d    = '0;
        pot_line_d = '0;
        if (!dump_q) begin
          state_d = ST_CHARGE;
          for (int i = 0; i < NUM_POTS; i++) begin
`ifdef POT_JITTER_EN
            // Current LFSR bit adds +0/+1 before the clamp; LFSR advances once per release.
            shadow_d[i] = clamp_pos({1'b0, pot_value[8*i +: 8]} + 9'(lfsr_q[i % 8]));
`else
            shadow_d[i] = clamp_pos({1'b0, pot_value[8*i +: 8]});
`endif
          end
`ifdef POT_JITTER_EN
          lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
        end
      end
      ST_CHARGE: begin
        if (dump_q) begin
          state_d    = ST_DUMP;
          pot_line_d = '0;
          count_d    = '0;
          presc_d    = '0;
        end else begin
          // Prescaler only runs in slow mode and keeps its phase across fast_scan changes.
          if (fast_scan) begin
            tick = 1'b1;
          end else if (presc_q == PRE_LAST) begin
            tick    = 1'b1;
            presc_d = '0;
          end else begin
            presc_d = presc_q + 1'b1;
          end
          if (tick && (count_q != CNT_MAX)) count_d = count_q + 1'b1;
          // Lines are sticky until the next dump.
          for (int i = 0; i < NUM_POTS; i++) begin
            if (count_q >= shadow_q[i]) pot_line_d[i] = 1'b1;
          end
          if ((count_q == CNT_MAX) || (&pot_line_q)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (dump_q) begin
          state_d    = ST_DUMP;
          pot_line_d = '0;
        end
      end
      default: begin
        state_d    = ST_DUMP;
        pot_line_d = '0;
      end
    endcase
    busy_d = (state_d == ST_CHARGE);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers; reset returns everything to the discharged state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dump_q     <= 1'b1;
      state_q    <= ST_DUMP;
      count_q    <= '0;
      presc_q    <= '0;
      pot_line_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < NUM_POTS; i++) shadow_q[i] <= '0;
`ifdef POT_JITTER_EN
      lfsr_q     <= 8'h01;
`endif
    end else begin
      dump_q     <= dump;
      state_q    <= state_d;
      count_q    <= count_d;
      presc_q    <= presc_d;
      pot_line_q <= pot_line_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      shadow_q   <= shadow_d;
`ifdef POT_JITTER_EN
      lfsr_q     <= lfsr_d;
`endif
    end
  end

  assign pot_line = pot_line_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pot_paddle_emulator.sv
// Directed bench for pot_paddle_emulator: reset, fast/slow scan timing, clamp, abort, jitter releases, async reset.
// Expected crossing times are hand formulas: (min(v+dither,228))*ticklen + 1 clk after CHARGE entry.
// Outputs are sampled on the falling edge; every wait is bounded.
module tb_pot_paddle_emulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        dump;
  logic        fast_scan;
  logic [15:0] pot_value;
  logic [1:0]  pot_line;
  logic        busy;
  logic        done;

  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] cur_off = 8'h00;
  logic [7:0] lfsr_model = 8'h01;

  pot_paddle_emulator #(.NUM_POTS(2), .TICK_DIV(114), .MAX_COUNT(228)) dut (
    .clk       (clk),
    .rst       (rst),
    .dump      (dump),
    .fast_scan (fast_scan),
    .pot_value (pot_value),
    .pot_line  (pot_line),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_rise(input int v, input int off, input int mult);
    int c;
    c = v + off;
    if (c > 228) c = 228;
    return c * mult + 1;
  endfunction

  // Release dump and wait (bounded) for CHARGE entry; returns on the sample where busy first reads 1.
  task automatic do_release();
    int found;
    @(negedge clk);
    dump = 1'b0;
`ifdef POT_JITTER_EN
    cur_off    = lfsr_model;
    lfsr_model = {lfsr_model[6:0], lfsr_model[7] ^ lfsr_model[5] ^ lfsr_model[4] ^ lfsr_model[3]};
`else
    cur_off    = 8'h00;
`endif
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk);
      if (busy === 1'b1) found = 1;
    end
    chk("charge_entry", found, 1);
  endtask

  // Follow one charge phase to DONE and check both crossing times and the done time.
  task automatic run_check(input string tag, input int v0, input int v1, input int mult);
    int e0, e1, ed, t0, t1, td;
    e0 = exp_rise(v0, int'(cur_off[0]), mult);
    e1 = exp_rise(v1, int'(cur_off[1]), mult);
    ed = ((e0 > e1) ? e0 : e1) + 1;
    if (ed > 228 * mult + 1) ed = 228 * mult + 1;
    t0 = -1; t1 = -1; td = -1;
    for (int n = 1; n <= 30000 && td < 0; n++) begin
      @(negedge clk);
      if (pot_line[0] === 1'b1 && t0 < 0) t0 = n;
      if (pot_line[1] === 1'b1 && t1 < 0) t1 = n;
      if (done === 1'b1) td = n;
    end
    chk({tag, "_rise0"}, t0, e0);
    chk({tag, "_rise1"}, t1, e1);
    chk({tag, "_done"}, td, ed);
    chk({tag, "_busy_at_done"}, int'(busy), 0);
    repeat (3) @(negedge clk);
    chk({tag, "_line_held"}, int'(pot_line), 3);
    chk({tag, "_done_held"}, int'(done), 1);
  endtask

  task automatic do_dump(input string tag);
    @(negedge clk);
    dump = 1'b1;
    repeat (3) @(negedge clk);
    chk({tag, "_dump_line"}, int'(pot_line), 0);
    chk({tag, "_dump_busy"}, int'(busy), 0);
    chk({tag, "_dump_done"}, int'(done), 0);
  endtask

  initial begin
    // Reset held with dump low: outputs stay quiet.
    rst       = 1'b1;
    dump      = 1'b0;
    fast_scan = 1'b0;
    pot_value = {8'd50, 8'd10};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_line", int'(pot_line), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
    end
    dump = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    // Fast scan, pots 5 and 20.
    fast_scan = 1'b1;
    pot_value = {8'd20, 8'd5};
    do_release();
    run_check("fast", 5, 20, 1);
    do_dump("fast");

    // Slow scan, pots 2 and 3 (114 clks per tick).
    fast_scan = 1'b0;
    pot_value = {8'd3, 8'd2};
    do_release();
    run_check("slow", 2, 3, 114);
    do_dump("slow");

    // Clamp: 255 saturates to 228, done comes from count saturation.
    fast_scan = 1'b1;
    pot_value = {8'd0, 8'd255};
    do_release();
    run_check("clamp", 255, 0, 1);
    do_dump("clamp");

    // Abort at tick 7; a mid-charge change to 3 must be ignored.
    pot_value = {8'd10, 8'd10};
    do_release();
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      if (n == 2) pot_value = {8'd3, 8'd3};
      if (n >= 4) chk("abort_line_quiet", int'(pot_line), 0);
    end
    dump = 1'b1;
    @(negedge clk);
    chk("abort_line_n8", int'(pot_line), 0);
    @(negedge clk);
    chk("abort_busy_n9", int'(busy), 0);
    chk("abort_line_n9", int'(pot_line), 0);
    repeat (2) @(negedge clk);
    pot_value = {8'd10, 8'd3};
    do_release();
    run_check("restart", 3, 10, 1);
    do_dump("restart");

    // Three releases with zero position: crossing follows the dither bits.
    pot_value = 16'h0000;
    for (int r = 0; r < 3; r++) begin
      do_release();
      run_check("zero", 0, 0, 1);
      do_dump("zero");
    end

    // Asynchronous reset in the middle of a charge phase.
    pot_value = {8'd0, 8'd0};
    do_release();
    repeat (3) @(negedge clk);
    chk("pre_rst_line", int'(pot_line), 3);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_line", int'(pot_line), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    @(negedge clk);
    chk("async_rst_line_hold", int'(pot_line), 0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
